// File: rtl/generic_sync_fifo_core.sv
// Single-clock FIFO: flat register store, registered read data (1-cycle latency), occupancy count.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module generic_sync_fifo_core #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 32,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign rd_ok = ren && !empty;
    // A read on a full FIFO frees the slot the write needs; no bypass when empty.
    assign wr_ok = wen && (!full || ren);

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_ok) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wen && full && !ren);
            underflow <= underflow | (ren && empty);
        end
    end
`endif

endmodule

// File: tb/tb_generic_sync_fifo_core.sv
// Bench for generic_sync_fifo_core: queue-based reference model, directed test plan, random traffic.
// Also checks overflow/underflow when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_generic_sync_fifo_core;

    localparam int DW = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1, clear = 1'b0, ren = 1'b0, wen = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          empty, full;
    logic [5:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    generic_sync_fifo_core #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .ren(ren), .rdata(rdata), .empty(empty),
        .wen(wen), .wdata(wdata), .full(full),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: contents as a queue, plus the last word handed out.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata = '0;
    bit            m_ovf = 1'b0, m_udf = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic w, input logic rd,
                              input logic [DW-1:0] d);
        bit do_rd, do_wr;
        if (r) begin
            q.delete(); m_rdata = '0; m_ovf = 0; m_udf = 0;
        end else if (c) begin
            q.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            do_rd = rd && q.size() > 0;
            do_wr = w && (q.size() < DEPTH || rd);
            if (w && q.size() == DEPTH && !rd) m_ovf = 1;
            if (rd && q.size() == 0) m_udf = 1;
            if (do_rd) m_rdata = q.pop_front();
            if (do_wr) q.push_back(d);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic w, input logic rd,
                        input logic [DW-1:0] d);
        rst = r; clear = c; wen = w; ren = rd; wdata = d;
        @(posedge clk);
        model_edge(r, c, w, rd, d);
        #1;
        rst = 0; clear = 0; wen = 0; ren = 0;
    endtask

    // Compare DUT against the model on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata", 32'(rdata), 32'(m_rdata));
            check("count", 32'(count), 32'(q.size()));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("full",  32'(full),  32'(q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check("overflow",  32'(overflow),  32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_udf));
`endif
        end
    end

    initial begin
        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_count", 32'(count), 0);
        check("rst_rdata", 32'(rdata), 0);

        // Basic order
        step(0, 0, 1, 0, 10); check("bo_cnt1", 32'(count), 1);
        step(0, 0, 1, 0, 11); check("bo_cnt2", 32'(count), 2);
        step(0, 0, 1, 0, 12); check("bo_cnt3", 32'(count), 3);
        step(0, 0, 0, 1, 0);  check("bo_rd10", 32'(rdata), 10); check("bo_cnt4", 32'(count), 2);
        step(0, 0, 0, 1, 0);  check("bo_rd11", 32'(rdata), 11); check("bo_cnt5", 32'(count), 1);
        step(0, 0, 0, 1, 0);  check("bo_rd12", 32'(rdata), 12); check("bo_cnt6", 32'(count), 0);
        check("bo_empty", 32'(empty), 1);

        // Concurrent streaming
        step(0, 0, 1, 0, 10); step(0, 0, 1, 0, 11); step(0, 0, 1, 0, 12);
        begin
            logic [DW-1:0] wv [5];
            logic [DW-1:0] rv [5];
            wv = '{8'd13, 8'd14, 8'd65, 8'd22, 8'd13};
            rv = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
            for (int i = 0; i < 5; i++) begin
                step(0, 0, 1, 1, wv[i]);
                check("cs_rdata", 32'(rdata), 32'(rv[i]));
                check("cs_count", 32'(count), 3);
            end
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        check("cs_tail", 32'(rdata), 13);

        // Fill / wrap
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, DW'(i));
        check("fw_full", 32'(full), 1);
        check("fw_cnt",  32'(count), 32);
        step(0, 0, 1, 0, 99);
        check("fw_drop", 32'(count), 32);
        step(0, 0, 1, 1, 40);
        check("fw_rd0",   32'(rdata), 0);
        check("fw_full2", 32'(full), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 0, 0, 1, 0);
            check("fw_drain", 32'(rdata), (i == DEPTH) ? 40 : i);
        end
        check("fw_empty", 32'(empty), 1);

        // Clear
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, DW'(50 + i));
        step(0, 1, 1, 1, 77);
        check("cl_count", 32'(count), 0);
        check("cl_empty", 32'(empty), 1);
        check("cl_rdata", 32'(rdata), 40);
        step(0, 0, 1, 0, 13);
        step(0, 0, 0, 1, 0);
        check("cl_rd13", 32'(rdata), 13);

        // Empty read+write
        step(0, 0, 1, 1, 7);
        check("er_count", 32'(count), 1);
        check("er_rdata", 32'(rdata), 13);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("er_udf", 32'(underflow), 1);
`endif
        step(0, 0, 0, 1, 0);
        check("er_rd7", 32'(rdata), 7);

        // Reset mid-stream
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, DW'(i + 3));
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 9);
        check("mr_count", 32'(count), 0);
        check("mr_rdata", 32'(rdata), 0);

        // Random traffic with occasional clear/reset
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 500) % 3;  // phases favouring fill, drain, balanced
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 3 : 5),
                 $urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 8 : 5),
                 DW'($urandom));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
